// File: rtl/inverter_arbiter.sv
// Two-requester arbiter sharing one external inverter.
// Burst-limited round robin, two-stage response pipeline, response counter.
module inverter_arbiter #(
    parameter int g_burst = 4,
    parameter int g_cntw  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              req0_valid,
    input  logic              req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_data,
    output logic              req1_ready,
    output logic              A,
    input  logic              Z,
    output logic              rsp0_valid,
    output logic              rsp0_data,
    output logic              rsp1_valid,
    output logic              rsp1_data,
    output logic [g_cntw-1:0] cnt
);

    localparam logic [3:0] BURST = 4'(g_burst);

    logic       last;
    logic [3:0] bcnt;
    logic       tag;
    logic       s1_valid;
    logic       gnt_any;
    logic       gnt_idx;
    logic       gnt_data;

    // Grant selection; bcnt==0 only right after reset, where 0 wins a tie
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (en && !reset) begin
            unique case ({req1_valid, req0_valid})
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    if (bcnt == 4'd0)
                        gnt_idx = 1'b0;
                    else if (bcnt < BURST)
                        gnt_idx = last;
                    else
                        gnt_idx = ~last;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
        gnt_data = gnt_idx ? req1_data : req0_data;
    end

    assign req0_ready = gnt_any & ~gnt_idx;
    assign req1_ready = gnt_any & gnt_idx;

    // Track last granted requester and length of its current run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
            bcnt <= 4'd0;
        end else if (gnt_any) begin
            last <= gnt_idx;
            if (gnt_idx != last)
                bcnt <= 4'd1;
            else if (bcnt != 4'd15)
                bcnt <= bcnt + 4'd1;
        end
    end

    // Stage 1: drive the inverter and remember who asked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A        <= 1'b0;
            tag      <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                A   <= gnt_data;
                tag <= gnt_idx;
            end
        end
    end

    // Stage 2: capture the inverter output and strobe the owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= 1'b0;
        end else begin
            rsp0_valid <= s1_valid & ~tag;
            rsp1_valid <= s1_valid & tag;
            if (s1_valid && !tag)
                rsp0_data <= Z;
            if (s1_valid && tag)
                rsp1_data <= Z;
        end
    end

    // Count delivered responses, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (rsp0_valid || rsp1_valid)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: tb/tb_inverter_arbiter.sv
// Directed bench for inverter_arbiter with a modelled inverter.
// Small counter width so the wrap is reachable quickly.
module tb_inverter_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       req0_valid;
    logic       req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_data;
    logic       req1_ready;
    logic       A;
    logic       Z;
    logic       rsp0_valid;
    logic       rsp0_data;
    logic       rsp1_valid;
    logic       rsp1_data;
    logic [3:0] cnt;

    int npass = 0;
    int ntot  = 0;

    inverter_arbiter #(
        .g_burst(4),
        .g_cntw (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .A         (A),
        .Z         (Z),
        .rsp0_valid(rsp0_valid),
        .rsp0_data (rsp0_data),
        .rsp1_valid(rsp1_valid),
        .rsp1_data (rsp1_data),
        .cnt       (cnt)
    );

    assign Z = ~A;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got == exp)
            npass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        en         = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 1'b0;
        req1_valid = 1'b0;
        req1_data  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    int s_pat[4]  = '{1, 0, 1, 1};
    int bg[10]    = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int e_dat[8]  = '{1, 1, 0, 1, 0, 1, 0, 1};
    int e_rsp[5]  = '{0, 0, 1, 1, 0};

    initial begin
        int nr;
        int en_k;

        // Reset values, readies blocked while reset is high
        reset      = 1'b1;
        en         = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 1'b1;
        step();
        step();
        chk("rst_A", int'(A), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_rv0", int'(rsp0_valid), 0);
        chk("rst_rv1", int'(rsp1_valid), 0);
        chk("rst_rd0", int'(rsp0_data), 0);
        chk("rst_rdy0", int'(req0_ready), 0);
        chk("rst_rdy1", int'(req1_ready), 0);

        // Single stream on requester 0
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req0_valid = (k < 4);
            req0_data  = (k < 4) ? s_pat[k][0] : 1'b0;
            @(negedge clk);
            if (k < 4)
                chk("s_rdy0", int'(req0_ready), 1);
            step();
            if (k >= 1 && k <= 4) begin
                chk("s_rv0", int'(rsp0_valid), 1);
                chk("s_rd0", int'(rsp0_data), 1 - s_pat[k-1]);
            end else begin
                chk("s_rv0_idle", int'(rsp0_valid), 0);
            end
        end
        chk("s_cnt", int'(cnt), 4);

        // Both requesters: burst limit alternation, first tie goes to 0
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = k[0];
            req1_data  = ~k[0];
            @(negedge clk);
            chk("b_rdy0", int'(req0_ready), int'(bg[k] == 0));
            chk("b_rdy1", int'(req1_ready), bg[k]);
            chk("b_excl", int'(req0_ready & req1_ready), 0);
            step();
            chk("b_rsp_excl", int'(rsp0_valid & rsp1_valid), 0);
            if (k >= 1)
                chk("b_rsp_own",
                    int'(bg[k-1] == 1 ? rsp1_valid : rsp0_valid), 1);
        end

        // Only requester 1 valid: no forced switch past the burst limit
        req0_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            req1_valid = (k < 10);
            req1_data  = k[0];
            @(negedge clk);
            if (k < 10) begin
                chk("p_rdy1", int'(req1_ready), 1);
                chk("p_rdy0", int'(req0_ready), 0);
            end
            step();
            if (k == 0) begin
                chk("p_tail0", int'(rsp0_valid), 1);
            end else begin
                chk("p_rv1", int'(rsp1_valid), 1);
                chk("p_rd1", int'(rsp1_data), 1 - ((k - 1) % 2));
            end
        end

        // Enable dropped for three cycles mid-stream
        do_reset();
        nr = 0;
        for (int k = 0; k < 11; k++) begin
            en_k       = (k >= 3 && k <= 5) ? 0 : 1;
            en         = en_k[0];
            req0_valid = (k < 8);
            req0_data  = (k < 8) ? e_dat[k][0] : 1'b0;
            @(negedge clk);
            if (k < 8)
                chk("e_rdy0", int'(req0_ready), en_k);
            step();
            if (rsp0_valid) begin
                if (nr < 5)
                    chk("e_data", int'(rsp0_data), e_rsp[nr]);
                nr++;
            end
        end
        chk("e_nrsp", nr, 5);
        chk("e_cnt", int'(cnt), 5);

        // Asynchronous reset with a transfer in flight
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1;
            req0_data  = s_pat[k][0];
            step();
        end
        chk("r_pre_cnt", int'(cnt), 2);
        chk("r_pre_rv0", int'(rsp0_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_A", int'(A), 0);
        chk("r_rv0", int'(rsp0_valid), 0);
        chk("r_rd0", int'(rsp0_data), 0);
        chk("r_cnt", int'(cnt), 0);
        chk("r_rdy0", int'(req0_ready), 0);
        step();
        reset      = 1'b0;
        req0_valid = 1'b0;
        step();
        chk("r_post_rv0", int'(rsp0_valid), 0);
        chk("r_post_rv1", int'(rsp1_valid), 0);
        chk("r_post_cnt", int'(cnt), 0);

        // Counter wrap over 17 transactions
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req0_valid = (k < 17);
            req0_data  = k[0];
            step();
            if (k == 16)
                chk("w_cnt15", int'(cnt), 15);
            if (k == 17)
                chk("w_cnt0", int'(cnt), 0);
            if (k >= 18)
                chk("w_cnt1", int'(cnt), 1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
